// File: rtl/perceptron_pkg.sv
// Shared sign-magnitude fixed-point datapath constants and conversions
// used by the perceptron multiplier and accumulator stages.
package perceptron_pkg;

  localparam int SIGN      = 1;
  localparam int Q_M       = 16;
  localparam int Q_N       = 16;
  localparam int W         = Q_M + Q_N;
  localparam int ACC_GUARD = 8;
  localparam int SM_W      = SIGN + W;
  localparam int ACC_W     = W + 1 + ACC_GUARD;

  typedef logic [SM_W-1:0]         sm_word_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic     ovf;
    sm_word_t word;
  } sm_sat_t;

  localparam acc_t ACC_MAX = acc_t'({1'b0, {(ACC_W-1){1'b1}}});
  localparam acc_t ACC_MIN = acc_t'({1'b1, {(ACC_W-2){1'b0}}, 1'b1});
  localparam acc_t MAG_MAX = acc_t'({{(ACC_W-W){1'b0}}, {W{1'b1}}});

  // Negative zero maps to +0 explicitly so no -0 pattern ever reaches the adder.
  function automatic acc_t sm_to_tc(input sm_word_t w);
    acc_t mag;
    mag = acc_t'({{(ACC_W-W){1'b0}}, w[W-1:0]});
    if (w[SM_W-1] && (mag != {ACC_W{1'b0}})) begin
      return -mag;
    end else begin
      return mag;
    end
  endfunction

  function automatic acc_t sat_add(input acc_t a, input acc_t b);
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    s  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    hi = {1'b0, ACC_MAX};
    lo = {1'b1, ACC_MIN};
    if (s > hi) begin
      return ACC_MAX;
    end else if (s < lo) begin
      return ACC_MIN;
    end else begin
      return s[ACC_W-1:0];
    end
  endfunction

  function automatic sm_sat_t tc_to_sm_sat(input acc_t v);
    sm_sat_t r;
    acc_t    mag;
    if (v[ACC_W-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
    if (mag > MAG_MAX) begin
      r.ovf  = 1'b1;
      r.word = {v[ACC_W-1], {W{1'b1}}};
    end else begin
      r.ovf  = 1'b0;
      r.word = {v[ACC_W-1], mag[W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/perceptron_accumulator_if.sv
// Product stream in, neuron result out, for the perceptron accumulator stage.
interface perceptron_accumulator_if;
  import perceptron_pkg::*;

  sm_word_t prod_in;
  logic     prod_valid_i;
  logic     prod_last_i;
  logic     prod_ready_o;
  sm_word_t bias_in;
  sm_word_t sum_out;
  logic     fire_out;
  logic     ovf_out;
  logic     out_valid_o;
  logic     out_ready_i;

  modport master (
    output prod_in, prod_valid_i, prod_last_i, bias_in, out_ready_i,
    input  prod_ready_o, sum_out, fire_out, ovf_out, out_valid_o
  );

  modport slave (
    input  prod_in, prod_valid_i, prod_last_i, bias_in, out_ready_i,
    output prod_ready_o, sum_out, fire_out, ovf_out, out_valid_o
  );
endinterface

// File: rtl/perceptron_accumulator.sv
// Sums a vector of sign-magnitude products plus bias with saturation and
// presents the clamped sum and step activation through a valid/ready result.
module perceptron_accumulator
  import perceptron_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  perceptron_accumulator_if.slave   bus
);

  typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} acc_state_t;

  acc_state_t state_q, state_d;
  acc_t       acc_q, acc_d;
  sm_word_t   sum_q, sum_d;
  logic       fire_q, fire_d;
  logic       ovf_q, ovf_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;

  logic       accept_s;
  acc_t       beat_sum_s;
  acc_t       total_s;
  sm_sat_t    conv_s;

  assign accept_s   = (state_q == ACCUM) && bus.prod_valid_i;
  assign beat_sum_s = sat_add(acc_q, sm_to_tc(bus.prod_in));
  assign total_s    = sat_add(beat_sum_s, sm_to_tc(bus.bias_in));
  assign conv_s     = tc_to_sm_sat(total_s);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    fire_d  = fire_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept_s && bus.prod_last_i) begin
          state_d = RESULT;
          acc_d   = {ACC_W{1'b0}};
          sum_d   = conv_s.word;
          // Activation uses the unclamped sum.
          fire_d  = !total_s[ACC_W-1] && (total_s != {ACC_W{1'b0}});
          ovf_d   = conv_s.ovf;
        end else if (accept_s) begin
          acc_d = beat_sum_s;
        end else begin
          acc_d = acc_q;
        end
      end
      RESULT: begin
        if (bus.out_ready_i) begin
          state_d = ACCUM;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = {ACC_W{1'b0}};
      end
    endcase
    ready_d = (state_d == ACCUM);
    valid_d = (state_d == RESULT);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ACCUM;
      acc_q   <= {ACC_W{1'b0}};
      sum_q   <= {SM_W{1'b0}};
      fire_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      fire_q  <= fire_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign bus.prod_ready_o = ready_q;
  assign bus.out_valid_o  = valid_q;
  assign bus.sum_out      = sum_q;
  assign bus.fire_out     = fire_q;
  assign bus.ovf_out      = ovf_q;

endmodule

// File: tb/tb_perceptron_accumulator.sv
// Self-checking bench for perceptron_accumulator against an integer reference model.
`timescale 1ns/1ps
module tb_perceptron_accumulator;
  import perceptron_pkg::*;

  localparam longint ACC_LIM = 64'd1099511627775;
  localparam longint MAG_LIM = 64'd4294967295;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  perceptron_accumulator_if bus();

  perceptron_accumulator dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic longint sm_val(input sm_word_t w);
    longint m;
    m = 0;
    m[31:0] = w[W-1:0];
    return w[SM_W-1] ? -m : m;
  endfunction

  function automatic longint clamp(input longint x);
    if (x > ACC_LIM) return ACC_LIM;
    if (x < -ACC_LIM) return -ACC_LIM;
    return x;
  endfunction

  function automatic logic [SM_W+1:0] model(input sm_word_t beats[$], input sm_word_t bias);
    longint acc;
    longint mag;
    logic   fire;
    logic   ovf;
    acc = 0;
    foreach (beats[i]) acc = clamp(acc + sm_val(beats[i]));
    acc  = clamp(acc + sm_val(bias));
    fire = (acc > 0);
    mag  = (acc < 0) ? -acc : acc;
    ovf  = (mag > MAG_LIM);
    if (ovf) mag = MAG_LIM;
    return {(acc < 0), mag[31:0], fire, ovf};
  endfunction

  function automatic sm_word_t rand_word();
    sm_word_t w;
    w[SM_W-1] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       w[W-1:0] = $urandom;
      1:       w[W-1:0] = 32'h0;
      default: w[W-1:0] = 32'($urandom_range(0, 32'h3FFFF));
    endcase
    return w;
  endfunction

  task automatic send_beat(input sm_word_t p, input logic last, input sm_word_t b);
    int guard = 0;
    bus.prod_in = p;
    bus.prod_last_i = last;
    bus.bias_in = b;
    bus.prod_valid_i = 1'b1;
    while (bus.prod_ready_o !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      compared++; mismatched++;
      $display("FAIL ready_timeout: prod_ready_o=%b, required 1", bus.prod_ready_o);
    end
    @(posedge clk); #1;
    bus.prod_valid_i = 1'b0;
    bus.prod_last_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (bus.out_valid_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (bus.out_valid_o === 1'b1);
  endtask

  task automatic release_result();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({bus.prod_ready_o, bus.out_valid_o} !== 2'b10) begin
      mismatched++;
      $display("FAIL reset_handshake: ready/valid=%b, required 10", {bus.prod_ready_o, bus.out_valid_o});
    end
    compared++;
    if ({bus.sum_out, bus.fire_out, bus.ovf_out} !== {(SM_W+2){1'b0}}) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h, required 0", {bus.sum_out, bus.fire_out, bus.ovf_out});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_signed_sum();
    sm_word_t q[$];
    bit ok;
    logic [SM_W+1:0] exp;
    q = '{33'h0_0001_8000, 33'h1_0000_8000};
    exp = model(q, 33'h0);
    send_beat(q[0], 1'b0, 33'h0);
    send_beat(q[1], 1'b1, 33'h0);
    wait_valid(ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL signed_sum_valid: out_valid_o=%b, required 1", bus.out_valid_o); end
    compared++;
    if ({bus.sum_out, bus.fire_out, bus.ovf_out} !== exp) begin
      mismatched++;
      $display("FAIL signed_sum: got %h, required %h", {bus.sum_out, bus.fire_out, bus.ovf_out}, exp);
    end
    compared++;
    if ({bus.sum_out, bus.fire_out, bus.ovf_out} !== {33'h0_0001_0000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL signed_sum_const: got %h, required sum 0x10000 fire 1 ovf 0", bus.sum_out);
    end
    release_result();
  endtask

  task automatic test_single_beat();
    sm_word_t q[$];
    logic [SM_W+1:0] exp;
    q = '{33'h1_0002_0000};
    exp = model(q, 33'h0_0001_0000);
    compared++;
    if (bus.out_valid_o !== 1'b0) begin mismatched++; $display("FAIL single_pre_valid: got %b, required 0", bus.out_valid_o); end
    send_beat(q[0], 1'b1, 33'h0_0001_0000);
    compared++;
    if ({bus.out_valid_o, bus.prod_ready_o} !== 2'b10) begin
      mismatched++;
      $display("FAIL single_latency: valid/ready=%b, required 10", {bus.out_valid_o, bus.prod_ready_o});
    end
    compared++;
    if ({bus.sum_out, bus.fire_out, bus.ovf_out} !== exp || exp !== {33'h1_0001_0000, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL single_beat: got %h, required %h", {bus.sum_out, bus.fire_out, bus.ovf_out}, exp);
    end
    release_result();
  endtask

  task automatic test_neg_zero();
    bit ok;
    send_beat(33'h1_0000_0000, 1'b1, 33'h1_0000_0000);
    wait_valid(ok);
    compared++;
    if (!ok || {bus.sum_out, bus.fire_out, bus.ovf_out} !== {(SM_W+2){1'b0}}) begin
      mismatched++;
      $display("FAIL neg_zero: got %h valid %b, required all zero", {bus.sum_out, bus.fire_out, bus.ovf_out}, ok);
    end
    release_result();
  endtask

  task automatic test_saturation();
    sm_word_t q[$];
    sm_word_t w;
    bit ok;
    logic [SM_W+1:0] exp;
    for (int s = 0; s < 2; s++) begin
      w = {1'(s), 32'hFFFF_FFFF};
      q = '{w, w, w};
      exp = model(q, 33'h0);
      send_beat(w, 1'b0, 33'h0);
      send_beat(w, 1'b0, 33'h0);
      send_beat(w, 1'b1, 33'h0);
      wait_valid(ok);
      compared++;
      if (!ok || {bus.sum_out, bus.fire_out, bus.ovf_out} !== exp
          || exp !== {1'(s), 32'hFFFF_FFFF, ~1'(s), 1'b1}) begin
        mismatched++;
        $display("FAIL saturation_%0d: got %h, required %h", s, {bus.sum_out, bus.fire_out, bus.ovf_out}, exp);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    sm_word_t q[$];
    sm_word_t held;
    bit ok;
    logic [SM_W+1:0] exp;
    send_beat(33'h0_0001_0000, 1'b1, 33'h0);
    wait_valid(ok);
    held = bus.sum_out;
    q = '{33'h0_0000_8000};
    exp = model(q, 33'h0_0000_4000);
    bus.prod_in = q[0];
    bus.bias_in = 33'h0_0000_4000;
    bus.prod_last_i = 1'b1;
    bus.prod_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({bus.out_valid_o, bus.prod_ready_o} !== 2'b10 || bus.sum_out !== held || held !== 33'h0_0001_0000) begin
        mismatched++;
        $display("FAIL backpressure_hold_%0d: valid/ready=%b sum=%h, required 10 sum=%h",
                 i, {bus.out_valid_o, bus.prod_ready_o}, bus.sum_out, held);
      end
    end
    release_result();
    compared++;
    if ({bus.out_valid_o, bus.prod_ready_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL backpressure_bubble: valid/ready=%b, required 01", {bus.out_valid_o, bus.prod_ready_o});
    end
    @(posedge clk); #1;
    bus.prod_valid_i = 1'b0;
    bus.prod_last_i = 1'b0;
    compared++;
    if (bus.out_valid_o !== 1'b1 || {bus.sum_out, bus.fire_out, bus.ovf_out} !== exp) begin
      mismatched++;
      $display("FAIL backpressure_next: got %h valid %b, required %h", {bus.sum_out, bus.fire_out, bus.ovf_out}, bus.out_valid_o, exp);
    end
    release_result();
  endtask

  task automatic test_reset_mid_vector();
    bit ok;
    send_beat(33'h0_0001_0000, 1'b0, 33'h0);
    send_beat(33'h0_0001_0000, 1'b0, 33'h0);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus.out_valid_o, bus.prod_ready_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL reset_async: valid/ready=%b, required 01", {bus.out_valid_o, bus.prod_ready_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(33'h0_0000_4000, 1'b1, 33'h0);
    wait_valid(ok);
    compared++;
    if (!ok || {bus.sum_out, bus.fire_out, bus.ovf_out} !== {33'h0_0000_4000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_partial_drop: got %h, required sum 0x4000 fire 1", {bus.sum_out, bus.fire_out, bus.ovf_out});
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus.out_valid_o, bus.prod_ready_o, bus.sum_out, bus.fire_out} !== {2'b01, {(SM_W+1){1'b0}}}) begin
      mismatched++;
      $display("FAIL reset_in_result: valid=%b sum=%h, required valid 0 sum 0", bus.out_valid_o, bus.sum_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    sm_word_t q[$];
    sm_word_t bias;
    sm_word_t held;
    bit ok;
    int len;
    logic [SM_W+1:0] exp;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_word());
      bias = rand_word();
      exp = model(q, bias);
      for (int i = 0; i < len; i++) begin
        bus.out_ready_i = 1'($urandom_range(0, 1));
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          @(posedge clk); #1;
        end
        send_beat(q[i], (i == len - 1), bias);
      end
      bus.out_ready_i = 1'b0;
      wait_valid(ok);
      compared++;
      if (!ok || {bus.sum_out, bus.fire_out, bus.ovf_out} !== exp) begin
        mismatched++;
        $display("FAIL random_%0d: got %h valid %b, required %h", v, {bus.sum_out, bus.fire_out, bus.ovf_out}, ok, exp);
      end
      held = bus.sum_out;
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(posedge clk); #1;
        compared++;
        if (bus.out_valid_o !== 1'b1 || bus.sum_out !== held) begin
          mismatched++;
          $display("FAIL random_hold_%0d: sum=%h valid=%b, required %h valid 1", v, bus.sum_out, bus.out_valid_o, held);
        end
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    sm_word_t q[$];
    logic [SM_W+1:0] exp;
    bus.out_ready_i = 1'b1;
    bus.bias_in = 33'h0;
    bus.prod_last_i = 1'b1;
    bus.prod_in = rand_word();
    bus.prod_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      q = '{bus.prod_in};
      exp = model(q, 33'h0);
      @(posedge clk); #1;
      compared++;
      if (bus.out_valid_o !== 1'b1 || {bus.sum_out, bus.fire_out, bus.ovf_out} !== exp) begin
        mismatched++;
        $display("FAIL b2b_result_%0d: got %h valid %b, required %h", k, {bus.sum_out, bus.fire_out, bus.ovf_out}, bus.out_valid_o, exp);
      end
      bus.prod_in = rand_word();
      @(posedge clk); #1;
      compared++;
      if ({bus.out_valid_o, bus.prod_ready_o} !== 2'b01) begin
        mismatched++;
        $display("FAIL b2b_bubble_%0d: valid/ready=%b, required 01", k, {bus.out_valid_o, bus.prod_ready_o});
      end
    end
    bus.prod_valid_i = 1'b0;
    bus.prod_last_i = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    bus.prod_in = 33'h0;
    bus.prod_valid_i = 1'b0;
    bus.prod_last_i = 1'b0;
    bus.bias_in = 33'h0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_signed_sum();
    test_single_beat();
    test_neg_zero();
    test_saturation();
    test_backpressure();
    test_reset_mid_vector();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
